// File: rtl/freqdetect_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : freqdetect_pkg                                                   |
// | Purpose : Constants and types shared by the FFT RAM loader and the         |
// |           frequency detector that reads the same RAM.                      |
// | Contents: N (bins/frame), AW (address width), CW (component width),        |
// |           WORDW (packed RAM word width), loader_state_t.                   |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package freqdetect_pkg;

  localparam int N     = 1024;
  localparam int AW    = $clog2(N);
  localparam int CW    = 14;
  localparam int WORDW = 2 * CW;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    DONE = 2'd1,
    WAIT = 2'd2
  } loader_state_t;

endpackage
`default_nettype wire

// File: rtl/sat_shift.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : sat_shift                                                        |
// | Purpose : Arithmetic right shift of one signed component followed by a     |
// |           clamp to the signed CW-bit range. Purely combinational.          |
// | Ports   : x_i   [IW-1:0] signed input component                            |
// |           y_o   [CW-1:0] shifted and clamped component                     |
// |           sat_o          1 when the clamp changed the value                |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module sat_shift
  import freqdetect_pkg::*;
#(
  parameter int IW    = 16,
  parameter int SHIFT = 2
) (
  input  logic [IW-1:0] x_i,
  output logic [CW-1:0] y_o,
  output logic          sat_o
);

  localparam logic signed [IW-1:0] MAXV = IW'((2 ** (CW - 1)) - 1);
  localparam logic signed [IW-1:0] MINV = IW'(-(2 ** (CW - 1)));

  logic signed [IW-1:0] shifted;

  assign shifted = $signed(x_i) >>> SHIFT;

  always_comb begin
    sat_o = 1'b0;
    y_o   = shifted[CW-1:0];
    if (shifted > MAXV) begin
      sat_o = 1'b1;
      y_o   = MAXV[CW-1:0];
    end else if (shifted < MINV) begin
      sat_o = 1'b1;
      y_o   = MINV[CW-1:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/fftram_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : fftram_loader                                                    |
// | Purpose : Accepts natural-order complex FFT bins over valid/ready,         |
// |           saturates each component to 14 bits, writes the packed word at   |
// |           the bit-reversed bin address, pulses fftdone after a complete    |
// |           frame and stalls input until the detector returns detectdone.    |
// | Ports   : clk, KEY[0] (async active-low reset), in_valid/in_ready,         |
// |           in_real/in_imag/in_last, detectdone, ramwren/ramwaddr/ramdata,   |
// |           fftdone (pulse), satflag and framerr (sticky since reset).       |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module fftram_loader
  import freqdetect_pkg::*;
#(
  parameter int N      = freqdetect_pkg::N,
  parameter int AW     = $clog2(N),
  parameter int IW     = 16,
  parameter int SHIFT  = 2,
  parameter int BITREV = 1
) (
  input  logic             clk,
  input  logic [3:0]       KEY,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IW-1:0]    in_real,
  input  logic [IW-1:0]    in_imag,
  input  logic             in_last,
  input  logic             detectdone,
  output logic             ramwren,
  output logic [AW-1:0]    ramwaddr,
  output logic [WORDW-1:0] ramdata,
  output logic             fftdone,
  output logic             satflag,
  output logic             framerr
);

  localparam logic [AW-1:0] LAST_BIN = AW'(N - 1);

  logic rst_n;
  logic unused_key;

  loader_state_t    state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic             in_ready_q;
  logic             ramwren_q;
  logic [AW-1:0]    ramwaddr_q;
  logic [WORDW-1:0] ramdata_q;
  logic             fftdone_q;
  logic             satflag_q, satflag_d;
  logic             framerr_q, framerr_d;

  logic             xfer;
  logic [CW-1:0]    re_sat, im_sat;
  logic             re_clip, im_clip;
  logic [AW-1:0]    cnt_rev;
  logic [AW-1:0]    wr_addr;

  assign rst_n      = KEY[0];
  assign unused_key = ^KEY[3:1];

  sat_shift #(.IW(IW), .SHIFT(SHIFT)) u_sat_re (
    .x_i   (in_real),
    .y_o   (re_sat),
    .sat_o (re_clip)
  );

  sat_shift #(.IW(IW), .SHIFT(SHIFT)) u_sat_im (
    .x_i   (in_imag),
    .y_o   (im_sat),
    .sat_o (im_clip)
  );

  genvar gi;
  generate
    for (gi = 0; gi < AW; gi++) begin : g_rev
      assign cnt_rev[gi] = cnt_q[AW-1-gi];
    end
  endgenerate

  assign wr_addr = (BITREV != 0) ? cnt_rev : cnt_q;

  // in_ready_q is low in the cycle right after reset release even though the
  // state is already FILL, so the handshake must use it rather than the state.
  assign xfer = in_valid && in_ready_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    satflag_d = satflag_q;
    framerr_d = framerr_q;
    case (state_q)
      FILL: begin
        if (xfer) begin
          if (re_clip || im_clip) satflag_d = 1'b1;
          if (cnt_q == LAST_BIN) begin
            // A full frame always completes, even if in_last was missing.
            state_d = DONE;
            cnt_d   = '0;
            if (!in_last) framerr_d = 1'b1;
          end else if (in_last) begin
            // Early in_last: drop the partial frame and restart at bin 0.
            framerr_d = 1'b1;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DONE:    state_d = WAIT;
      WAIT:    if (detectdone) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FILL;
      cnt_q      <= '0;
      in_ready_q <= 1'b0;
      ramwren_q  <= 1'b0;
      ramwaddr_q <= '0;
      ramdata_q  <= '0;
      fftdone_q  <= 1'b0;
      satflag_q  <= 1'b0;
      framerr_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      in_ready_q <= (state_d == FILL);
      ramwren_q  <= xfer;
      if (xfer) begin
        ramwaddr_q <= wr_addr;
        ramdata_q  <= {re_sat, im_sat};
      end
      // Decoding the registered state puts fftdone one cycle after the last
      // RAM write, so the frame is complete before the detector starts.
      fftdone_q  <= (state_q == DONE);
      satflag_q  <= satflag_d;
      framerr_q  <= framerr_d;
    end
  end

  assign in_ready = in_ready_q;
  assign ramwren  = ramwren_q;
  assign ramwaddr = ramwaddr_q;
  assign ramdata  = ramdata_q;
  assign fftdone  = fftdone_q;
  assign satflag  = satflag_q;
  assign framerr  = framerr_q;

endmodule
`default_nettype wire

// File: tb/tb_fftram_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_fftram_loader                                                 |
// | Purpose : Scoreboard bench for fftram_loader. The driver computes each     |
// |           expected RAM write from a plain-arithmetic model and queues it;  |
// |           a negedge monitor pops and compares whenever ramwren is high.    |
// |           A second instance with SHIFT=1 makes saturation reachable,       |
// |           since at SHIFT=2 a 16-bit input always fits in 14 bits.          |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_fftram_loader;

  localparam int NB = 1024;

  logic        clk = 1'b0;
  logic [3:0]  KEY = 4'b1111;
  logic        in_valid = 1'b0;
  logic [15:0] in_real = '0;
  logic [15:0] in_imag = '0;
  logic        in_last = 1'b0;
  logic        detectdone = 1'b0;

  logic        in_ready, ramwren, fftdone, satflag, framerr;
  logic [9:0]  ramwaddr;
  logic [27:0] ramdata;

  logic        rdy1, wren1, done1, sat1, ferr1;
  logic [9:0]  waddr1;
  logic [27:0] data1;

  fftram_loader #(.SHIFT(2)) dut (
    .clk(clk), .KEY(KEY), .in_valid(in_valid), .in_ready(in_ready),
    .in_real(in_real), .in_imag(in_imag), .in_last(in_last),
    .detectdone(detectdone), .ramwren(ramwren), .ramwaddr(ramwaddr),
    .ramdata(ramdata), .fftdone(fftdone), .satflag(satflag), .framerr(framerr)
  );

  fftram_loader #(.SHIFT(1)) dut_s1 (
    .clk(clk), .KEY(KEY), .in_valid(in_valid), .in_ready(rdy1),
    .in_real(in_real), .in_imag(in_imag), .in_last(in_last),
    .detectdone(detectdone), .ramwren(wren1), .ramwaddr(waddr1),
    .ramdata(data1), .fftdone(done1), .satflag(sat1), .framerr(ferr1)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [9:0]  addr;
    logic [27:0] d2;
    logic [27:0] d1;
    bit          s2;
    bit          s1;
    bit          ferr;
    bit          last;
  } wr_t;

  wr_t sb[$];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // model state (driver side)
  bit exp_ready = 1'b0;
  bit m_ready   = 1'b0;
  bit m_dc      = 1'b0;
  int m_bin     = 0;
  bit m_sat2    = 1'b0;
  bit m_sat1    = 1'b0;
  bit m_ferr    = 1'b0;
  int m_frames  = 0;

  // monitor state
  bit fft_exp  = 1'b0;
  int fft_seen = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [13:0] sat14(input logic [15:0] x, input int sh, output bit s);
    int v;
    v = int'($signed(x)) >>> sh;
    s = 1'b0;
    if (v > 8191) begin
      v = 8191;
      s = 1'b1;
    end else if (v < -8192) begin
      v = -8192;
      s = 1'b1;
    end
    return 14'(v);
  endfunction

  function automatic logic [9:0] rev10(input int k);
    int r = 0;
    int t = k;
    for (int i = 0; i < 10; i++) begin
      r = r * 2 + (t % 2);
      t = t / 2;
    end
    return 10'(r);
  endfunction

  // One cycle of stimulus, entered and left at posedge+1.
  task automatic drive(input bit v, input logic [15:0] re, input logic [15:0] im,
                       input bit last, input bit dd);
    wr_t it;
    bit sa, sb_, sc, sd, fin, nxt;
    logic [13:0] a, b, c, d;
    in_valid   = v;
    in_real    = re;
    in_imag    = im;
    in_last    = last;
    detectdone = dd;
    exp_ready  = m_ready;
    nxt        = m_ready;
    fin        = 1'b0;
    if (v && m_ready) begin
      a = sat14(re, 2, sa);
      b = sat14(im, 2, sb_);
      c = sat14(re, 1, sc);
      d = sat14(im, 1, sd);
      m_sat2 |= sa | sb_;
      m_sat1 |= sc | sd;
      fin = (m_bin == NB - 1);
      if (fin != last) m_ferr = 1'b1;
      it = '{cyc: cyc + 1, addr: rev10(m_bin), d2: {a, b}, d1: {c, d},
             s2: m_sat2, s1: m_sat1, ferr: m_ferr, last: fin};
      sb.push_back(it);
      if (fin) begin
        m_bin = 0;
        nxt = 1'b0;
        m_frames++;
      end else if (last) begin
        m_bin = 0;
      end else begin
        m_bin++;
      end
    end else if (!m_ready && dd && !m_dc) begin
      nxt = 1'b1;
    end
    @(posedge clk);
    #1;
    m_ready = nxt;
    m_dc    = fin;
  endtask

  task automatic apply_reset();
    KEY[0]     = 1'b0;
    in_valid   = 1'b0;
    in_last    = 1'b0;
    detectdone = 1'b0;
    exp_ready  = 1'b0;
    m_ready    = 1'b0;
    m_dc       = 1'b0;
    m_bin      = 0;
    m_sat2     = 1'b0;
    m_sat1     = 1'b0;
    m_ferr     = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_ramwren", ramwren, 0);
    chk("rst_ramwaddr", ramwaddr, 0);
    chk("rst_ramdata", ramdata, 0);
    chk("rst_fftdone", fftdone, 0);
    chk("rst_satflag", satflag, 0);
    chk("rst_framerr", framerr, 0);
    repeat (3) @(posedge clk);
    #1;
    KEY[0] = 1'b1;
    @(posedge clk);
    #1;
    m_ready = 1'b1;
  endtask

  // Offer bins until nb have been accepted; pv = percent of cycles with valid.
  task automatic send_frame(input int nb, input int pv, input bit rnd, input bit with_last);
    int sent = 0;
    int guard = 0;
    while (sent < nb && guard < 20000) begin
      bit v, acc, lst;
      logic [15:0] re, im;
      v = ($urandom_range(99) < pv);
      if (rnd) begin
        re = 16'($urandom);
        im = 16'($urandom);
      end else begin
        re = 16'(m_bin * 4);
        im = 16'h0000;
      end
      acc = v && m_ready;
      lst = with_last && v && (sent + 1 == nb);
      drive(v, re, im, lst, 1'b0);
      if (acc) sent++;
      guard++;
    end
    if (sent < nb) chk("frame_timeout", sent, nb);
  endtask

  // Monitor: pops the scoreboard whenever the DUT writes.
  initial forever begin
    wr_t it;
    @(negedge clk);
    if (!KEY[0]) begin
      sb.delete();
      fft_exp = 1'b0;
    end
    chk("in_ready", in_ready, exp_ready);
    if (fftdone || fft_exp) chk("fftdone", fftdone, fft_exp);
    if (fftdone) fft_seen++;
    fft_exp = 1'b0;
    if (ramwren) begin
      if (sb.size() == 0) begin
        chk("unexpected_write", ramwren, 0);
      end else begin
        it = sb.pop_front();
        chk("write_cycle", cyc, it.cyc);
        chk("ramwaddr", ramwaddr, it.addr);
        chk("ramdata", ramdata, it.d2);
        chk("satflag", satflag, it.s2);
        chk("framerr", framerr, it.ferr);
        chk("wren_s1", wren1, 1);
        chk("ramdata_s1", data1, it.d1);
        chk("satflag_s1", sat1, it.s1);
        if (it.last) fft_exp = 1'b1;
      end
    end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
      void'(sb.pop_front());
      chk("missing_write", ramwren, 1);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    apply_reset();

    // Ramp frame: real = 4k, imag = 0, every cycle valid.
    send_frame(NB, 100, 1'b0, 1'b1);

    // WAIT: valid held high must not produce writes; then release.
    repeat (50) drive(1'b1, 16'($urandom), 16'($urandom), 1'b0, 1'b0);
    drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);

    // Full-scale bin lands at address 0 (exactly at the rails for SHIFT=2,
    // clamped for SHIFT=1).
    drive(1'b1, 16'h7FFF, 16'h8000, 1'b0, 1'b0);

    // Early in_last on bin 500, then a throttled random frame from address 0.
    send_frame(500, 70, 1'b1, 1'b1);
    send_frame(NB, 50, 1'b1, 1'b1);
    repeat (3) drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);

    // Abandon a frame at bin 700 with reset, then a complete frame.
    send_frame(700, 60, 1'b1, 1'b0);
    repeat (2) drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    apply_reset();
    send_frame(NB, 60, 1'b1, 1'b1);
    repeat (4) drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);

    chk("fftdone_count", fft_seen, m_frames);
    chk("scoreboard_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
